// File: rtl/dp_pkg.sv
// Shared types and default timing for the multi-channel digital-pot wiper driver.
package dp_pkg;

  localparam int unsigned PULSE_HALF_DEF = 50;
  localparam int unsigned SETUP_DEF      = 10;
  localparam int unsigned STORE_CYC_DEF  = 1000;

  // Fixed-width command container; the top slices out the bits its parameters need.
  localparam int unsigned CH_MAX_W  = 3;
  localparam int unsigned POS_MAX_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_HOME    = 3'd2,
    ST_TURN    = 3'd3,
    ST_STEP_LO = 3'd4,
    ST_STEP_HI = 3'd5,
    ST_DESEL   = 3'd6,
    ST_RECOVER = 3'd7
  } state_e;

  typedef struct packed {
    logic [CH_MAX_W-1:0]  ch;
    logic [POS_MAX_W-1:0] pos;
    logic                 store;
  } cmd_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dp_timer.sv
// Loadable down-counter with a zero flag; a state loaded with N-1 lasts N cycles.
module dp_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dp_multi_wiper.sv
// Multi-channel X9C-style digital-pot driver: tracks wiper positions, homes on
// first use and produces timed INC pulses on shared INC/U-D lines.
module dp_multi_wiper
  import dp_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned TAPS       = 100,
  parameter int unsigned POS_W      = 7,
  parameter int unsigned PULSE_HALF = PULSE_HALF_DEF,
  parameter int unsigned SETUP      = SETUP_DEF,
  parameter int unsigned STORE_CYC  = STORE_CYC_DEF,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [POS_W-1:0]  cmd_pos,
  input  logic              cmd_store,
  output logic              done,
  output logic              busy,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [POS_W-1:0]  rd_pos,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] dp_cs_n,
  output logic              dp_inc_n,
  output logic              dp_ud
);

  localparam int unsigned     TW       = $clog2(max3(PULSE_HALF, SETUP, STORE_CYC) + 1);
  localparam logic [POS_W-1:0] TOP_POS = POS_W'(TAPS - 1);
  localparam logic [POS_W-1:0] ONE_POS = POS_W'(1);
  localparam logic [TW-1:0]    LD_SETUP = TW'(SETUP - 1);
  localparam logic [TW-1:0]    LD_PULSE = TW'(PULSE_HALF - 1);
  localparam logic [TW-1:0]    LD_STORE = TW'(STORE_CYC - 1);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ud_q, ud_d;
  logic              inc_n_q, inc_n_d;
  logic              homing_q, homing_d;
  logic [NUM_CH-1:0] cs_n_q, cs_n_d;
  logic [POS_W-1:0]  rem_q, rem_d;
  logic [POS_W-1:0]  pos_q [NUM_CH];
  logic [NUM_CH-1:0] known_q;

  logic              pos_we, known_set;
  logic [POS_W-1:0]  pos_wval;
  logic              tmr_load, tmr_zero;
  logic [TW-1:0]     tmr_val;
  logic              enter_lo, enter_desel;

  logic [CH_W-1:0]   ch;
  logic [POS_W-1:0]  tgt;
  logic              ch_ok;
  logic [POS_W-1:0]  cur_pos;
  logic              cur_known;
  logic [POS_W-1:0]  cmd_pos_clamped;
  logic              unused_cmd_bits;

  assign ch              = cmd_q.ch[CH_W-1:0];
  assign tgt             = cmd_q.pos[POS_W-1:0];
  assign ch_ok           = 32'(ch) < NUM_CH;
  assign cmd_pos_clamped = (cmd_pos > TOP_POS) ? TOP_POS : cmd_pos;
  assign unused_cmd_bits = ^{cmd_q.ch, cmd_q.pos};

  // Mux per channel rather than index directly, so a non-power-of-two NUM_CH never reads past the array.
  always_comb begin
    cur_pos   = '0;
    cur_known = 1'b0;
    rd_pos    = '0;
    rd_valid  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) begin
        cur_pos   = pos_q[i];
        cur_known = known_q[i];
      end
      if (rd_ch == CH_W'(i)) begin
        rd_pos   = pos_q[i];
        rd_valid = known_q[i];
      end
    end
  end

  dp_timer #(.W(TW)) u_timer (
    .clk_i      (clk_in),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cs_n_d      = cs_n_q;
    inc_n_d     = inc_n_q;
    ud_d        = ud_q;
    rem_d       = rem_q;
    homing_d    = homing_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    pos_we      = 1'b0;
    pos_wval    = cur_pos;
    known_set   = 1'b0;
    enter_lo    = 1'b0;
    enter_desel = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!busy_q) begin
          if (cmd_valid) begin
            cmd_d.ch    = CH_MAX_W'(cmd_ch);
            cmd_d.pos   = POS_MAX_W'(cmd_pos_clamped);
            cmd_d.store = cmd_store;
            busy_d      = 1'b1;
          end
        end else if (!ch_ok || (cur_known && (tgt == cur_pos) && !cmd_q.store)) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          // CS fall and U/D set share one edge so a single SETUP wait covers both.
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            cs_n_d[i] = (ch != CH_W'(i));
          end
          state_d  = ST_SELECT;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
          if (!cur_known) begin
            ud_d     = 1'b0;
            rem_d    = TOP_POS;
            homing_d = 1'b1;
          end else begin
            ud_d     = (tgt > cur_pos);
            rem_d    = (tgt > cur_pos) ? (tgt - cur_pos) : (cur_pos - tgt);
            homing_d = 1'b0;
          end
        end
      end

      ST_SELECT, ST_TURN: begin
        if (tmr_zero) begin
          if (rem_q == '0) enter_desel = 1'b1;
          else             enter_lo    = 1'b1;
        end
      end

      // One-cycle commit after the homing sweep: wiper is now known to be at tap 0.
      ST_HOME: begin
        pos_we    = 1'b1;
        pos_wval  = '0;
        known_set = 1'b1;
        homing_d  = 1'b0;
        ud_d      = (tgt != '0);
        rem_d     = tgt;
        state_d   = ST_TURN;
        tmr_load  = 1'b1;
        tmr_val   = LD_SETUP;
      end

      ST_STEP_LO: begin
        if (tmr_zero) begin
          if ((rem_q == ONE_POS) && !cmd_q.store && !homing_q) begin
            enter_desel = 1'b1;
          end else begin
            state_d  = ST_STEP_HI;
            inc_n_d  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = LD_PULSE;
          end
        end
      end

      ST_STEP_HI: begin
        if (tmr_zero) begin
          rem_d = rem_q - ONE_POS;
          if (rem_q == ONE_POS) begin
            if (homing_q) state_d = ST_HOME;
            else          enter_desel = 1'b1;
          end else begin
            enter_lo = 1'b1;
          end
        end
      end

      ST_DESEL: begin
        inc_n_d  = 1'b1;
        state_d  = ST_RECOVER;
        tmr_load = 1'b1;
        tmr_val  = cmd_q.store ? LD_STORE : LD_PULSE;
      end

      ST_RECOVER: begin
        if (tmr_zero) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (enter_lo) begin
      state_d  = ST_STEP_LO;
      inc_n_d  = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = LD_PULSE;
      if (!homing_q) begin
        pos_we = 1'b1;
        if (ud_q) pos_wval = (cur_pos == TOP_POS) ? cur_pos : (cur_pos + ONE_POS);
        else      pos_wval = (cur_pos == '0)      ? cur_pos : (cur_pos - ONE_POS);
      end
    end

    if (enter_desel) begin
      state_d = ST_DESEL;
      cs_n_d  = '1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ud_q     <= 1'b0;
      inc_n_q  <= 1'b1;
      homing_q <= 1'b0;
      cs_n_q   <= '1;
      rem_q    <= '0;
      known_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pos_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ud_q     <= ud_d;
      inc_n_q  <= inc_n_d;
      homing_q <= homing_d;
      cs_n_q   <= cs_n_d;
      rem_q    <= rem_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (pos_we && (ch == CH_W'(i))) pos_q[i] <= pos_wval;
        if (known_set && (ch == CH_W'(i))) known_q[i] <= 1'b1;
      end
    end
  end

  assign cmd_ready = ~busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dp_cs_n   = cs_n_q;
  assign dp_inc_n  = inc_n_q;
  assign dp_ud     = ud_q;

endmodule

// File: tb/tb_dp_multi_wiper.sv
// Directed bench for dp_multi_wiper: command table plus timing and reset sequences.
module tb_dp_multi_wiper;

  localparam int PH = 4;
  localparam int SU = 3;
  localparam int SC = 20;
  localparam int LIMIT = 5000;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_ch;
  logic [6:0] cmd_pos;
  logic       cmd_store;
  logic       done;
  logic       busy;
  logic [1:0] rd_ch;
  logic [6:0] rd_pos;
  logic       rd_valid;
  logic [3:0] dp_cs_n;
  logic       dp_inc_n;
  logic       dp_ud;

  dp_multi_wiper #(
    .NUM_CH     (4),
    .TAPS       (100),
    .POS_W      (7),
    .PULSE_HALF (PH),
    .SETUP      (SU),
    .STORE_CYC  (SC)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_pos   (cmd_pos),
    .cmd_store (cmd_store),
    .done      (done),
    .busy      (busy),
    .rd_ch     (rd_ch),
    .rd_pos    (rd_pos),
    .rd_valid  (rd_valid),
    .dp_cs_n   (dp_cs_n),
    .dp_inc_n  (dp_inc_n),
    .dp_ud     (dp_ud)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Pin monitor: cumulative counters, sampled on the falling clock edge.
  int falls_up = 0, falls_dn = 0, stores = 0, done_cnt = 0, toggles = 0;
  int low_bad = 0, low_ok = 0, setup_bad = 0, ud_bad = 0, multi_cs = 0, cs_bad = 0, order_bad = 0;
  int cs_low_cnt [4] = '{0, 0, 0, 0};
  int since = 1000, low_len = 0;
  logic seen_up = 1'b0, prev_inc = 1'b1, prev_ud = 1'b0;
  logic [3:0] prev_cs = 4'hF;

  always @(negedge clk_in) begin
    if ((dp_ud != prev_ud) || (|(prev_cs & ~dp_cs_n))) since = 0;
    else if (since < 100000) since = since + 1;
    if (prev_inc && !dp_inc_n) begin
      if (dp_ud) begin
        falls_up = falls_up + 1;
        seen_up = 1'b1;
      end else begin
        falls_dn = falls_dn + 1;
        if (seen_up) order_bad = order_bad + 1;
      end
      if (since < SU) setup_bad = setup_bad + 1;
      if (&dp_cs_n) cs_bad = cs_bad + 1;
      low_len = 1;
    end else if (!dp_inc_n) begin
      low_len = low_len + 1;
    end
    if (!prev_inc && dp_inc_n && !(&prev_cs) && !(&dp_cs_n)) begin
      if (low_len != PH) low_bad = low_bad + 1;
      else low_ok = low_ok + 1;
    end
    if ((dp_ud != prev_ud) && (!dp_inc_n || !prev_inc)) ud_bad = ud_bad + 1;
    if ($countones(~dp_cs_n) > 1) multi_cs = multi_cs + 1;
    if ((|(~prev_cs & dp_cs_n)) && dp_inc_n) stores = stores + 1;
    if (&dp_cs_n) seen_up = 1'b0;
    if ((dp_cs_n != prev_cs) || (dp_inc_n != prev_inc) || (dp_ud != prev_ud)) toggles = toggles + 1;
    for (int i = 0; i < 4; i++) if (!dp_cs_n[i]) cs_low_cnt[i] = cs_low_cnt[i] + 1;
    if (done) done_cnt = done_cnt + 1;
    prev_inc = dp_inc_n;
    prev_ud  = dp_ud;
    prev_cs  = dp_cs_n;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_cmd(input int ch, input int pos, input int st);
    @(negedge clk_in);
    cmd_valid = 1'b1;
    cmd_ch    = 2'(ch);
    cmd_pos   = 7'(pos);
    cmd_store = st[0];
    @(posedge clk_in);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int got;
    got = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk_in);
      if (done) begin
        got = 1;
        break;
      end
    end
    check({name, "_done_in_time"}, got, 1);
  endtask

  typedef struct {
    int ch; int pos; int st;
    int exp_up; int exp_dn; int exp_rd; int exp_store;
  } vec_t;

  vec_t vecs [9];

  int s_up, s_dn, s_st, s_done, s_tog, s_ord, s_cs0, s_cs1, s_cs2, s_cs3, busy_cnt, hit;

  initial begin
    vecs[0] = '{1,   5, 0,  5, 99,  5, 0};  // first use: home then climb
    vecs[1] = '{1,   2, 0,  0,  3,  2, 0};
    vecs[2] = '{1,   2, 0,  0,  0,  2, 0};  // already there
    vecs[3] = '{1,   2, 1,  0,  0,  2, 1};  // store only
    vecs[4] = '{0,  98, 0, 98, 99, 98, 0};
    vecs[5] = '{0, 120, 0,  1,  0, 99, 0};  // clamped to 99
    vecs[6] = '{0, 127, 1,  0,  0, 99, 1};  // clamp equals pos, store only
    vecs[7] = '{2,  99, 1, 99, 99, 99, 1};  // home, full climb, store
    vecs[8] = '{2,   0, 0,  0, 99,  0, 0};

    reset = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_pos = '0; cmd_store = 1'b0; rd_ch = '0;
    repeat (3) @(negedge clk_in);
    check("rst_cs_n", int'(dp_cs_n), 15);
    check("rst_inc_n", int'(dp_inc_n), 1);
    check("rst_ud", int'(dp_ud), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cmd_ready), 1);
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      #1;
      check("rst_rd_pos", int'(rd_pos), 0);
      check("rst_rd_valid", int'(rd_valid), 0);
    end
    @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);

    for (int v = 0; v < 9; v++) begin
      s_up = falls_up; s_dn = falls_dn; s_st = stores; s_done = done_cnt; s_ord = order_bad;
      s_cs0 = cs_low_cnt[0]; s_cs2 = cs_low_cnt[2]; s_cs3 = cs_low_cnt[3];
      start_cmd(vecs[v].ch, vecs[v].pos, vecs[v].st);
      wait_done("vec");
      repeat (2) @(negedge clk_in);
      rd_ch = 2'(vecs[v].ch);
      #1;
      check("vec_up_falls", falls_up - s_up, vecs[v].exp_up);
      check("vec_dn_falls", falls_dn - s_dn, vecs[v].exp_dn);
      check("vec_stores", stores - s_st, vecs[v].exp_store);
      check("vec_done_pulses", done_cnt - s_done, 1);
      check("vec_order", order_bad - s_ord, 0);
      check("vec_rd_pos", int'(rd_pos), vecs[v].exp_rd);
      check("vec_rd_valid", int'(rd_valid), 1);
      if (v == 1) begin
        check("vec1_cs0_high", cs_low_cnt[0] - s_cs0, 0);
        check("vec1_cs2_high", cs_low_cnt[2] - s_cs2, 0);
        check("vec1_cs3_high", cs_low_cnt[3] - s_cs3, 0);
      end
    end

    // No-op: done one cycle after the accept cycle, pins untouched.
    s_tog = toggles;
    start_cmd(1, 0, 0);
    wait_done("prep");
    repeat (2) @(negedge clk_in);
    s_tog = toggles;
    start_cmd(1, 0, 0);
    @(negedge clk_in);
    check("noop_busy", int'(busy), 1);
    check("noop_ready", int'(cmd_ready), 0);
    check("noop_done_early", int'(done), 0);
    @(negedge clk_in);
    check("noop_done", int'(done), 1);
    check("noop_busy_clr", int'(busy), 0);
    repeat (2) @(negedge clk_in);
    check("noop_toggles", toggles - s_tog, 0);

    // Store-only with a competing command offered while busy.
    s_up = falls_up; s_dn = falls_dn; s_st = stores; s_cs1 = cs_low_cnt[1]; s_cs3 = cs_low_cnt[3];
    busy_cnt = 0;
    start_cmd(1, 0, 1);
    cmd_ch = 2'd3; cmd_pos = 7'd7; cmd_store = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < LIMIT && busy; i++) begin
      @(negedge clk_in);
      if (i == 5) cmd_valid = 1'b0;
      if (busy) busy_cnt = busy_cnt + 1;
    end
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    check("store_busy_ge", int'(busy_cnt >= SC), 1);
    check("store_cs_low", cs_low_cnt[1] - s_cs1, SU);
    check("store_falls", (falls_up - s_up) + (falls_dn - s_dn), 0);
    check("store_count", stores - s_st, 1);
    check("busy_reject_cs3", cs_low_cnt[3] - s_cs3, 0);
    rd_ch = 2'd3;
    #1 check("busy_reject_rd_valid", int'(rd_valid), 0);

    // Reset in the middle of a STEP_HI phase.
    s_up = falls_up;
    hit = 0;
    start_cmd(1, 50, 0);
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk_in);
      if ((falls_up - s_up >= 2) && dp_inc_n) begin
        hit = 1;
        break;
      end
    end
    check("reset_reach_hi", hit, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_cs_n", int'(dp_cs_n), 15);
    check("midrst_inc_n", int'(dp_inc_n), 1);
    check("midrst_ud", int'(dp_ud), 0);
    check("midrst_busy", int'(busy), 0);
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      #1 check("midrst_rd_valid", int'(rd_valid), 0);
    end
    @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    s_up = falls_up; s_dn = falls_dn; s_ord = order_bad;
    start_cmd(1, 3, 0);
    wait_done("rehome");
    repeat (2) @(negedge clk_in);
    rd_ch = 2'd1;
    #1;
    check("rehome_dn", falls_dn - s_dn, 99);
    check("rehome_up", falls_up - s_up, 3);
    check("rehome_order", order_bad - s_ord, 0);
    check("rehome_rd_pos", int'(rd_pos), 3);

    check("pin_low_phase", low_bad, 0);
    check("pin_low_phase_seen", int'(low_ok > 0), 1);
    check("pin_setup", setup_bad, 0);
    check("pin_ud_while_low", ud_bad, 0);
    check("pin_multi_cs", multi_cs, 0);
    check("pin_inc_fall_cs_high", cs_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
